arb_puf_eval_ctrl: RTL and testbench

//  Challenge/evaluation controller for the arbiter PUF delay chain.
//  - Upstream: drives the per-stage mux selects (challenge) and the common launch edge into both racing paths.
//  - Downstream: consumes the arbiter flop output, synchronises it, and repeats the race NUM_EVAL times.
//  - Returns a majority-voted response bit plus a stability flag.

---
 rtl/arb_puf_eval_ctrl.sv | 133 +++++++++++++
 tb/tb_arb_puf_eval_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/arb_puf_eval_ctrl.sv
// Challenge/evaluation controller for an arbiter PUF delay chain.
// Applies a registered challenge, then fires the launch edge NUM_EVAL
// times. After each race it samples the 2FF-synchronised arbiter output
// and reports a majority-voted response with a stability flag.
//
// Handshake: a request is accepted on a rising edge where istart && oready.
// oready is high only in IDLE, so a request during an evaluation is dropped
// and never queued. ovalid is a one-cycle pulse. oresp/oones/ostable hold
// until the next result or until reset.
module arb_puf_eval_ctrl #(
  parameter int CHAL_W     = 64,
  parameter int SETTLE_CYC = 16,
  parameter int NUM_EVAL   = 7,
  parameter int CNT_W      = $clog2(NUM_EVAL + 1)
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              istart,
  input  logic [CHAL_W-1:0] ichal,
  output logic              oready,
  output logic [CHAL_W-1:0] ochal,
  output logic              olaunch,
  output logic              oarb_clr,
  input  logic              iarb,
  output logic              oresp,
  output logic [CNT_W-1:0]  oones,
  output logic              ostable,
  output logic              ovalid
);

  localparam int PH_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_FIRE   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_REARM  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] EVAL_MAX = CNT_W'(NUM_EVAL);
  localparam logic [CNT_W-1:0] MAJ_THR  = CNT_W'((NUM_EVAL + 1) / 2);

  // Reject parameter sets that break the majority vote or the sync margin.
  if ((NUM_EVAL < 1) || ((NUM_EVAL % 2) == 0) || (SETTLE_CYC < 3)) begin : g_bad_params
    $error("arb_puf_eval_ctrl: NUM_EVAL must be odd and >=1, SETTLE_CYC must be >=3");
  end

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] eval_cnt;
  logic [CNT_W-1:0] ones_cnt;
  logic             arb_s1;
  logic             arb_s2;

  // Next-state selection. Each phase lasts SETTLE_CYC cycles, timed by phase.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (istart) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_FIRE;
      S_FIRE:   if (phase == PH_LAST) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = S_REARM;
      S_REARM:  if (phase == PH_LAST) state_nxt = (eval_cnt == EVAL_MAX) ? S_DONE : S_FIRE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Two-flop synchroniser for the asynchronous arbiter output.
  always_ff @(posedge iclk) begin
    if (irst) begin
      arb_s1 <= 1'b0;
      arb_s2 <= 1'b0;
    end else begin
      arb_s1 <= iarb;
      arb_s2 <= arb_s1;
    end
  end

  // State register, phase timer and evaluation/ones counters.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state    <= S_IDLE;
      phase    <= '0;
      eval_cnt <= '0;
      ones_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        phase <= '0;
      else if ((state == S_FIRE) || (state == S_REARM))
        phase <= phase + 1'b1;
      if ((state == S_IDLE) && istart) begin
        eval_cnt <= '0;
        ones_cnt <= '0;
      end else if (state == S_SAMPLE) begin
        // Only NUM_EVAL samples are taken, so ones_cnt cannot wrap.
        eval_cnt <= eval_cnt + 1'b1;
        ones_cnt <= ones_cnt + CNT_W'(arb_s2);
      end
    end
  end

  // Registered outputs are decoded from the next state so that they line up
  // with the state they describe.
  always_ff @(posedge iclk) begin
    if (irst) begin
      oready   <= 1'b1;
      ochal    <= '0;
      olaunch  <= 1'b0;
      oarb_clr <= 1'b0;
      oresp    <= 1'b0;
      oones    <= '0;
      ostable  <= 1'b0;
      ovalid   <= 1'b0;
    end else begin
      oready   <= (state_nxt == S_IDLE);
      olaunch  <= (state_nxt == S_FIRE) || (state_nxt == S_SAMPLE);
      oarb_clr <= (state_nxt == S_LOAD) || (state_nxt == S_REARM);
      ovalid   <= (state_nxt == S_DONE);
      if ((state == S_IDLE) && istart)
        ochal <= ichal;
      if (state_nxt == S_DONE) begin
        oones   <= ones_cnt;
        oresp   <= (ones_cnt >= MAJ_THR);
        ostable <= (ones_cnt == '0) || (ones_cnt == EVAL_MAX);
      end
    end
  end

endmodule

// File: tb/tb_arb_puf_eval_ctrl.sv
// Directed bench for arb_puf_eval_ctrl with CHAL_W=8, SETTLE_CYC=4 and
// NUM_EVAL=3. A table of challenge/arbiter patterns is run with their
// expected votes. Hand-written sequences then cover reset and a reset
// applied in the middle of a run.
module tb_arb_puf_eval_ctrl;

  localparam int CHAL_W = 8;
  localparam int SETTLE = 4;
  localparam int NEVAL  = 3;
  localparam int CNT_W  = 2;
  localparam int LAT    = 1 + NEVAL * (2 * SETTLE + 1);

  logic              clk;
  logic              irst;
  logic              istart;
  logic [CHAL_W-1:0] ichal;
  logic              oready;
  logic [CHAL_W-1:0] ochal;
  logic              olaunch;
  logic              oarb_clr;
  logic              iarb;
  logic              oresp;
  logic [CNT_W-1:0]  oones;
  logic              ostable;
  logic              ovalid;

  int n_pass;
  int n_total;

  arb_puf_eval_ctrl #(
    .CHAL_W(CHAL_W), .SETTLE_CYC(SETTLE), .NUM_EVAL(NEVAL), .CNT_W(CNT_W)
  ) dut (
    .iclk(clk), .irst(irst), .istart(istart), .ichal(ichal),
    .oready(oready), .ochal(ochal), .olaunch(olaunch), .oarb_clr(oarb_clr),
    .iarb(iarb), .oresp(oresp), .oones(oones), .ostable(ostable), .ovalid(ovalid)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] chal;
    logic [2:0] bits;    // bits[k] is the arbiter value for race k
    bit         inject;  // pulse istart with ichal=0 in the middle of the run
    logic       resp;
    logic [1:0] ones;
    logic       stable;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full evaluation and checks waveform, latency and result.
  task automatic do_run(input logic [7:0] chal, input logic [2:0] bits, input bit inject,
                        input logic er, input logic [1:0] eo, input logic es);
    int   nvalid, vt, pulses, hi_len, bad_w, ovl, bad_chal, waitc;
    logic prev_l;
    logic rr, rs;
    logic [1:0] ro;
    nvalid = 0; vt = -1; pulses = 0; hi_len = 0; bad_w = 0; ovl = 0; bad_chal = 0;
    rr = 1'bx; rs = 1'bx; ro = 2'bxx;
    waitc = 0;
    while (!oready && waitc < 20) begin
      tick();
      waitc++;
    end
    chk("ready_before_start", 32'(oready), 32'd1);
    ichal  = chal;
    iarb   = bits[0];
    istart = 1'b1;
    tick();
    istart = 1'b0;
    ichal  = 8'h5A;
    chk("load_launch", 32'(olaunch), 32'd0);
    chk("load_arb_clr", 32'(oarb_clr), 32'd1);
    chk("busy_ready", 32'(oready), 32'd0);
    prev_l = 1'b0;
    for (int t = 0; t <= 40; t++) begin
      if (t > 0) tick();
      istart = inject && (t == 10);
      if (inject && (t == 10)) ichal = 8'h00;
      if (ochal !== chal) bad_chal++;
      if (olaunch && oarb_clr) ovl++;
      if (olaunch && !prev_l) begin
        if (pulses < 3) iarb = bits[pulses];
        pulses++;
        hi_len = 0;
      end
      if (olaunch) hi_len++;
      if (!olaunch && prev_l && hi_len != SETTLE + 1) bad_w++;
      if (ovalid) begin
        nvalid++;
        vt = t;
        rr = oresp;
        ro = oones;
        rs = ostable;
      end
      prev_l = olaunch;
    end
    istart = 1'b0;
    chk("ovalid_count", 32'(nvalid), 32'd1);
    chk("latency", 32'(vt), 32'(LAT));
    chk("oresp", 32'(rr), 32'(er));
    chk("oones", 32'(ro), 32'(eo));
    chk("ostable", 32'(rs), 32'(es));
    chk("launch_pulses", 32'(pulses), 32'(NEVAL));
    chk("launch_width_errs", 32'(bad_w), 32'd0);
    chk("launch_clr_overlap", 32'(ovl), 32'd0);
    chk("ochal_changes", 32'(bad_chal), 32'd0);
    chk("hold_oones", 32'(oones), 32'(eo));
    chk("hold_oresp", 32'(oresp), 32'(er));
    chk("idle_ready", 32'(oready), 32'd1);
  endtask

  // Main sequence.
  initial begin
    int nv;
    n_pass = 0; n_total = 0;
    irst = 1'b1; istart = 1'b0; ichal = '0; iarb = 1'b0;

    vecs[0] = '{chal: 8'hA5, bits: 3'b111, inject: 1'b1, resp: 1'b1, ones: 2'd3, stable: 1'b1};
    vecs[1] = '{chal: 8'hA5, bits: 3'b101, inject: 1'b0, resp: 1'b1, ones: 2'd2, stable: 1'b0};
    vecs[2] = '{chal: 8'hFF, bits: 3'b000, inject: 1'b0, resp: 1'b0, ones: 2'd0, stable: 1'b1};
    vecs[3] = '{chal: 8'h3C, bits: 3'b010, inject: 1'b0, resp: 1'b0, ones: 2'd1, stable: 1'b0};

    // Reset held for two cycles.
    tick();
    tick();
    chk("rst_oready", 32'(oready), 32'd1);
    chk("rst_olaunch", 32'(olaunch), 32'd0);
    chk("rst_ovalid", 32'(ovalid), 32'd0);
    chk("rst_oones", 32'(oones), 32'd0);
    chk("rst_ochal", 32'(ochal), 32'd0);
    chk("rst_arb_clr", 32'(oarb_clr), 32'd0);
    irst = 1'b0;
    tick();

    foreach (vecs[i])
      do_run(vecs[i].chal, vecs[i].bits, vecs[i].inject, vecs[i].resp, vecs[i].ones, vecs[i].stable);

    // Reset during the second FIRE phase (cycles 10..13 after accept).
    ichal = 8'hC3; iarb = 1'b1; istart = 1'b1;
    tick();
    istart = 1'b0;
    for (int t = 1; t <= 11; t++) tick();
    chk("mid_fire_launch", 32'(olaunch), 32'd1);
    irst = 1'b1;
    tick();
    chk("mid_rst_launch", 32'(olaunch), 32'd0);
    chk("mid_rst_ready", 32'(oready), 32'd1);
    chk("mid_rst_ochal", 32'(ochal), 32'd0);
    chk("mid_rst_oones", 32'(oones), 32'd0);
    chk("mid_rst_ovalid", 32'(ovalid), 32'd0);
    irst = 1'b0;
    nv = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (ovalid) nv++;
    end
    chk("mid_rst_no_valid", 32'(nv), 32'd0);
    do_run(8'h81, 3'b111, 1'b0, 1'b1, 2'd3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
